// File: rtl/countdown100.sv
// ---------------------------------------------------------------------------
// countdown100
//
// Two-digit BCD countdown timer (99..00) with a programmable prescaler.
// A preset is loaded with LOAD. START begins counting down from IDLE. PAUSE
// freezes the count while running. BR pulses for one cycle when the count
// reaches 00 from a nonzero value.
//
// Parameters
//   PRESCALE     un-paused RUN cycles per decrement, 1..1023
//
// Ports
//   CLK          clock, all state changes on the rising edge
//   RST          synchronous active-high reset
//   LOAD         load LOAD_FIRST/LOAD_SECOND (clamped to 9) and go IDLE
//   LOAD_FIRST   BCD preset for the tens digit
//   LOAD_SECOND  BCD preset for the ones digit
//   START        begin the countdown (only honoured in IDLE)
//   PAUSE        level-sensitive hold while running
//   CNT_first    current tens digit (registered)
//   CNT_second   current ones digit (registered)
//   BR           one-cycle borrow pulse, coincident with the first 00
//   BUSY         high while in RUN
//   ZERO         high while in DONE
// ---------------------------------------------------------------------------
module countdown100 #(
   parameter int PRESCALE = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       LOAD,
   input  logic [3:0] LOAD_FIRST,
   input  logic [3:0] LOAD_SECOND,
   input  logic       START,
   input  logic       PAUSE,
   output logic [3:0] CNT_first,
   output logic [3:0] CNT_second,
   output logic       BR,
   output logic       BUSY,
   output logic       ZERO
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } stateType;

   // The prescaler counts 0..PRESCALE-1; the decrement happens in the cycle
   // where it sits on its last phase.
   localparam logic [9:0] LastPhase = 10'(PRESCALE - 1);

   stateType   state;
   logic [9:0] prescaleCnt;

   logic       tickNow;
   logic       countIsOne;
   logic       countIsZero;
   logic [3:0] decFirst;
   logic [3:0] decSecond;

   // Presets above 9 are not valid BCD, so they saturate to 9 on load.
   function automatic logic [3:0] clampDigit(input logic [3:0] digit);
      return (digit > 4'd9) ? 4'd9 : digit;
   endfunction

   // Tick detection and the BCD decrement of the current count. The
   // decrement is only used while running, and RUN is never entered or kept
   // with a count of 00, so the tens digit never underflows here.
   always_comb begin
      tickNow     = (state == RUN) && !PAUSE && (prescaleCnt == LastPhase);
      countIsOne  = (CNT_first == 4'd0) && (CNT_second == 4'd1);
      countIsZero = (CNT_first == 4'd0) && (CNT_second == 4'd0);
      decFirst    = CNT_first;
      decSecond   = CNT_second;
      if (CNT_second != 4'd0) begin
         decSecond = CNT_second - 4'd1;
      end else begin
         decSecond = 4'd9;
         decFirst  = CNT_first - 4'd1;
      end
   end

   // Main state machine. Every output is a register written here, so nothing
   // combinational reaches the ports. Priority is reset, then LOAD, then the
   // per-state START/PAUSE handling. BR defaults low each cycle so it can
   // only ever be a single-cycle pulse, and a LOAD that lands on the final
   // tick overrides the tick, so no borrow is produced in that case.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         prescaleCnt <= '0;
         CNT_first   <= 4'd0;
         CNT_second  <= 4'd0;
         BR          <= 1'b0;
         BUSY        <= 1'b0;
         ZERO        <= 1'b0;
      end else if (LOAD) begin
         state       <= IDLE;
         prescaleCnt <= '0;
         CNT_first   <= clampDigit(LOAD_FIRST);
         CNT_second  <= clampDigit(LOAD_SECOND);
         BR          <= 1'b0;
         BUSY        <= 1'b0;
         ZERO        <= 1'b0;
      end else begin
         BR <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  prescaleCnt <= '0;
                  if (countIsZero) begin
                     state <= DONE;
                     ZERO  <= 1'b1;
                  end else begin
                     state <= RUN;
                     BUSY  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (tickNow) begin
                  prescaleCnt <= '0;
                  CNT_first   <= decFirst;
                  CNT_second  <= decSecond;
                  if (countIsOne) begin
                     state <= DONE;
                     BR    <= 1'b1;
                     BUSY  <= 1'b0;
                     ZERO  <= 1'b1;
                  end
               end else if (!PAUSE) begin
                  prescaleCnt <= prescaleCnt + 10'd1;
               end
            end
            DONE: begin
               prescaleCnt <= '0;
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
               ZERO  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_countdown100.sv
// ---------------------------------------------------------------------------
// tb_countdown100
//
// Scoreboard bench for countdown100. Two instances run side by side: one
// with PRESCALE=1 and one with PRESCALE=4. Only one is exercised at a time
// while the other is held in reset. Each stimulus cycle pushes the
// hand-computed outputs expected after the next rising edge. A monitor per
// instance pops and compares them shortly after that edge.
// ---------------------------------------------------------------------------
module tb_countdown100;

   typedef struct {
      logic [3:0] first;
      logic [3:0] second;
      logic       br;
      logic       busy;
      logic       zero;
      string      name;
   } expType;

   logic       CLK;
   logic [1:0] rstV;
   logic [1:0] loadV;
   logic [1:0] startV;
   logic [1:0] pauseV;
   logic [3:0] loadFirst  [2];
   logic [3:0] loadSecond [2];
   logic [3:0] cntFirst   [2];
   logic [3:0] cntSecond  [2];
   logic [1:0] brV;
   logic [1:0] busyV;
   logic [1:0] zeroV;

   expType expQ0[$];
   expType expQ1[$];

   int checks = 0;
   int errors = 0;

   countdown100 #(.PRESCALE(1)) dutFast (
      .CLK        (CLK),
      .RST        (rstV[0]),
      .LOAD       (loadV[0]),
      .LOAD_FIRST (loadFirst[0]),
      .LOAD_SECOND(loadSecond[0]),
      .START      (startV[0]),
      .PAUSE      (pauseV[0]),
      .CNT_first  (cntFirst[0]),
      .CNT_second (cntSecond[0]),
      .BR         (brV[0]),
      .BUSY       (busyV[0]),
      .ZERO       (zeroV[0])
   );

   countdown100 #(.PRESCALE(4)) dutSlow (
      .CLK        (CLK),
      .RST        (rstV[1]),
      .LOAD       (loadV[1]),
      .LOAD_FIRST (loadFirst[1]),
      .LOAD_SECOND(loadSecond[1]),
      .START      (startV[1]),
      .PAUSE      (pauseV[1]),
      .CNT_first  (cntFirst[1]),
      .CNT_second (cntSecond[1]),
      .BR         (brV[1]),
      .BUSY       (busyV[1]),
      .ZERO       (zeroV[1])
   );

   // Free-running 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Compare one instance's outputs against a popped expectation.
   task automatic checkOutput(input int sel, input expType e);
      checks++;
      if (cntFirst[sel] !== e.first || cntSecond[sel] !== e.second ||
          brV[sel] !== e.br || busyV[sel] !== e.busy || zeroV[sel] !== e.zero) begin
         errors++;
         $display("[TB] FAIL %s (dut%0d): got cnt=%0d%0d br=%0b busy=%0b zero=%0b, expected cnt=%0d%0d br=%0b busy=%0b zero=%0b",
                  e.name, sel, cntFirst[sel], cntSecond[sel], brV[sel], busyV[sel], zeroV[sel],
                  e.first, e.second, e.br, e.busy, e.zero);
      end
   endtask

   // Monitors: sample just after each rising edge and check whatever the
   // stimulus side queued for that edge.
   always @(posedge CLK) begin : monFast
      expType e;
      #1;
      if (expQ0.size() > 0) begin
         e = expQ0.pop_front();
         checkOutput(0, e);
      end
   end

   always @(posedge CLK) begin : monSlow
      expType e;
      #1;
      if (expQ1.size() > 0) begin
         e = expQ1.pop_front();
         checkOutput(1, e);
      end
   end

   // Drive one cycle of inputs on the selected instance (the other is held
   // in reset) and queue the outputs expected after the next rising edge.
   task automatic applyStimulus(input int sel, input logic rst, input logic load,
                                input logic [3:0] lf, input logic [3:0] ls,
                                input logic start, input logic pause,
                                input logic [3:0] ef, input logic [3:0] es,
                                input logic ebr, input logic ebusy, input logic ezero,
                                input string name);
      expType e;
      @(negedge CLK);
      rstV[sel]       = rst;
      loadV[sel]      = load;
      loadFirst[sel]  = lf;
      loadSecond[sel] = ls;
      startV[sel]     = start;
      pauseV[sel]     = pause;
      rstV[1-sel]     = 1'b1;
      loadV[1-sel]    = 1'b0;
      startV[1-sel]   = 1'b0;
      pauseV[1-sel]   = 1'b0;
      e.first  = ef;
      e.second = es;
      e.br     = ebr;
      e.busy   = ebusy;
      e.zero   = ezero;
      e.name   = name;
      if (sel == 0) expQ0.push_back(e);
      else          expQ1.push_back(e);
   endtask

   initial begin
      int n;
      rstV   = 2'b11;
      loadV  = 2'b00;
      startV = 2'b00;
      pauseV = 2'b00;
      for (int i = 0; i < 2; i++) begin
         loadFirst[i]  = 4'd0;
         loadSecond[i] = 4'd0;
      end

      // Reset, including LOAD/START being ignored while RST is high.
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
      applyStimulus(0, 1, 1, 5, 5, 1, 0, 0, 0, 0, 0, 0, "reset_ignores_load");

      // Count 25 down to 00 at one decrement per cycle.
      applyStimulus(0, 0, 1, 2, 5, 0, 0, 2, 5, 0, 0, 0, "load25");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 2, 5, 0, 1, 0, "start25");
      for (n = 24; n >= 1; n--) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'(n / 10), 4'(n % 10), 0, 1, 0, "count25");
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "borrow25");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "done_hold1");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "done_hold2");

      // Tens borrow 10 -> 09 -> 08, then clamp of an out-of-range preset.
      applyStimulus(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, "load10");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, "start10");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 1, 0, "tens_borrow09");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 1, 0, "count08");
      applyStimulus(0, 0, 1, 4'hF, 4'hC, 0, 0, 9, 9, 0, 0, 0, "load_clamp99");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 0, "idle_holds99");

      // START with 00 goes straight to DONE without a borrow; repeat START.
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "load00");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, "start00_done");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, "start_in_done");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "done_after_start");

      // Reset in the middle of a run while showing 37.
      applyStimulus(0, 0, 1, 3, 8, 0, 0, 3, 8, 0, 0, 0, "load38");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 3, 8, 0, 1, 0, "start38");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 7, 0, 1, 0, "run37");
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "rst_mid_run");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_after_rst1");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_after_rst2");

      // LOAD coinciding with the final 01 -> 00 tick wins.
      applyStimulus(0, 0, 1, 0, 3, 0, 0, 0, 3, 0, 0, 0, "load03");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 1, 0, "start03");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, "run02");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "run01");
      applyStimulus(0, 0, 1, 4, 2, 0, 0, 4, 2, 0, 0, 0, "load_beats_tick");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4, 2, 0, 0, 0, "idle42_no_br");

      // PRESCALE=4: 02 -> 01 after 4 cycles, 00 after 8.
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "p4_reset");
      applyStimulus(1, 0, 1, 0, 2, 0, 0, 0, 2, 0, 0, 0, "p4_load02");
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 2, 0, 1, 0, "p4_start");
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, "p4_hold02");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "p4_at4_01");
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "p4_hold01");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "p4_at8_00");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "p4_done");

      // Same run with a 5-cycle pause mid-period: 00 arrives 5 cycles late.
      applyStimulus(1, 0, 1, 0, 2, 0, 0, 0, 2, 0, 0, 0, "p4p_load02");
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 2, 0, 1, 0, "p4p_start");
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, "p4p_hold02");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "p4p_at4_01");
      for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "p4p_pre_pause");
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, "p4p_paused");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "p4p_resume");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, "p4p_at13_00");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "p4p_done");

      // Let the monitors drain, bounded.
      n = 0;
      while ((expQ0.size() > 0 || expQ1.size() > 0) && n < 10) begin
         @(negedge CLK);
         n++;
      end
      if (expQ0.size() > 0 || expQ1.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d pending expectations, expected 0",
                  expQ0.size() + expQ1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/countdown100.md
COUNTDOWN100 -- requirements
Module: countdown100

Interface
REQ-001 Parameter PRESCALE, default 1: number of un-paused RUN cycles per decrement; legal range 1..1023.
REQ-002 Port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 Port LOAD, input, 1 bit: loads the preset digits.
REQ-005 Port LOAD_FIRST, input, 4 bits: BCD preset for the tens digit.
REQ-006 Port LOAD_SECOND, input, 4 bits: BCD preset for the ones digit.
REQ-007 Port START, input, 1 bit: begins the countdown from IDLE.
REQ-008 Port PAUSE, input, 1 bit: level-sensitive hold while in RUN.
REQ-009 Port CNT_first, output, 4 bits: current tens digit, BCD.
REQ-010 Port CNT_second, output, 4 bits: current ones digit, BCD.
REQ-011 Port BR, output, 1 bit: one-cycle borrow pulse when the count reaches 00 from a nonzero value.
REQ-012 Port BUSY, output, 1 bit: high while in RUN.
REQ-013 Port ZERO, output, 1 bit: high when the state is DONE.

Function
REQ-014 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-015 Priority SHALL be RST, then LOAD, then START/PAUSE.
REQ-016 LOAD SHALL act in any state and take effect on the next edge.
- Digits are set to LOAD_FIRST and LOAD_SECOND; any digit value above 9 is clamped to 9.
- The prescaler is cleared.
- The state becomes IDLE.
REQ-017 In IDLE, START with a nonzero count SHALL enter RUN and clear the prescaler; START with count 00 SHALL enter DONE with no BR pulse.
REQ-018 START in RUN or DONE SHALL be ignored.
REQ-019 In RUN with PAUSE=0, the prescaler SHALL increment each cycle; a tick occurs in the cycle where the prescaler equals PRESCALE-1, and the prescaler wraps to 0.
REQ-020 In RUN with PAUSE=1, the prescaler and digits SHALL hold, and BUSY SHALL stay high.
REQ-021 On a tick, the count SHALL decrement by one in BCD; the new value is visible one edge after the tick cycle.
- If ones > 0, ones decrements.
- If ones = 0, ones becomes 9 and tens decrements.
REQ-022 A tick that takes the count from 01 to 00 SHALL move the state to DONE and assert BR for exactly the next cycle, coincident with the first cycle that CNT shows 00.
REQ-023 With PRESCALE=1, a count of N (0..99, nonzero) SHALL reach 00 exactly N cycles after the START edge.
REQ-024 The count SHALL never wrap below 00; DONE holds 00 until LOAD or RST.
REQ-025 Outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-026 LOAD asserted in the same cycle as a 01->00 tick SHALL win: digits take the preset, state becomes IDLE, and no BR pulse is produced.
REQ-027 Deasserting PAUSE SHALL resume counting from the held prescaler value, with no extra or lost tick.

Reset
REQ-028 While RST=1 at an edge, the next state SHALL be:
- CNT_first=0, CNT_second=0, prescaler=0, state=IDLE.
- BR=0, BUSY=0, ZERO=0.
REQ-029 RST asserted mid-RUN SHALL abort the count with no BR pulse.
REQ-030 All inputs other than RST SHALL be ignored during any cycle where RST=1.

Verification
REQ-031 The bench SHALL cover: PRESCALE=1, LOAD 2/5 then START -> BUSY=1; count 25,24,...,01,00; BR high one cycle with CNT=00; ZERO=1 from that cycle on.
REQ-032 The bench SHALL cover: PRESCALE=1, LOAD 1/0, START -> next values 09, 08 (tens borrow); LOAD F/C -> CNT_first=9, CNT_second=9.
REQ-033 The bench SHALL cover: PRESCALE=4, LOAD 0/2, START -> CNT=01 after 4 cycles, 00 after 8; PAUSE for 5 cycles mid-period -> completion delayed by exactly 5 cycles.
REQ-034 The bench SHALL cover: LOAD 0/0, START -> ZERO=1, BR never asserted; START again in DONE -> no change.
REQ-035 The bench SHALL cover: RST pulsed while RUN at 37 -> next cycle CNT=00, BUSY=0, ZERO=0, BR=0; IDLE retained after RST drops.
REQ-036 The bench SHALL cover: LOAD 4/2 in the same cycle as the 01->00 tick -> CNT=42, state IDLE, BR stays 0.
